// File: rtl/vga_text_if.sv
// Signal bundle for the 80x25 text renderer: timing inputs, char/font memory ports, DAC outputs.
// The cursor position inputs exist only when CURSOR_EN is defined.
interface vga_text_if #(
  parameter int ADDR_W = 11
);
  logic [9:0]        iX;
  logic [9:0]        iY;
  logic              iVGA_BLANK_N;
  logic              iVGA_HS;
  logic              iVGA_VS;
  logic [ADDR_W-1:0] oCHAR_ADDR;
  logic [15:0]       iCHAR_DATA;
  logic [11:0]       oFONT_ADDR;
  logic [7:0]        iFONT_DATA;
  logic [9:0]        oVGA_R;
  logic [9:0]        oVGA_G;
  logic [9:0]        oVGA_B;
  logic              oVGA_HS;
  logic              oVGA_VS;
  logic              oVGA_BLANK_N;
`ifdef CURSOR_EN
  logic [6:0]        iCURSOR_COL;
  logic [4:0]        iCURSOR_ROW;
`endif

  // Renderer side.
  modport master (
    input  iX, iY, iVGA_BLANK_N, iVGA_HS, iVGA_VS, iCHAR_DATA, iFONT_DATA,
`ifdef CURSOR_EN
    input  iCURSOR_COL, iCURSOR_ROW,
`endif
    output oCHAR_ADDR, oFONT_ADDR, oVGA_R, oVGA_G, oVGA_B,
    output oVGA_HS, oVGA_VS, oVGA_BLANK_N
  );

  // Timing generator, memories and DAC side.
  modport slave (
    output iX, iY, iVGA_BLANK_N, iVGA_HS, iVGA_VS, iCHAR_DATA, iFONT_DATA,
`ifdef CURSOR_EN
    output iCURSOR_COL, iCURSOR_ROW,
`endif
    input  oCHAR_ADDR, oFONT_ADDR, oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_HS, oVGA_VS, oVGA_BLANK_N
  );
endinterface

// File: rtl/vga_text_renderer.sv
// 80x25 text-mode pixel stage: char RAM -> font ROM -> 16-colour palette, 4-edge latency.
// Define CURSOR_EN to add a blinking underline cursor driven by a VS-based frame counter.
module vga_text_renderer #(
  parameter int ADDR_W = 11,
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int CELL_H = 14,
  parameter bit HS_ACT = 1'b0,
  parameter bit VS_ACT = 1'b1
) (
  input logic        iVGA_CLK,
  input logic        iRST_N,
  vga_text_if.master vga
);
  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
  localparam logic [3:0] LAST_LINE = 4'(CELL_H - 1);
  localparam logic [5:0] ROW_LIM   = 6'(ROWS);

  function automatic logic [9:0] chanLevel(input logic c, input logic i);
    if (c) return i ? 10'h3FF : 10'h2AA;
    else   return i ? 10'h155 : 10'h000;
  endfunction

  // Index bits are {I,R,G,B}; result is {R,G,B} at 10 bits per channel.
  function automatic logic [29:0] paletteRgb(input logic [3:0] idx);
    return {chanLevel(idx[2], idx[3]), chanLevel(idx[1], idx[3]), chanLevel(idx[0], idx[3])};
  endfunction

  logic [9:0]        prevY;
  logic [3:0]        lineQ;
  logic [3:0]        lineCur;
  logic [5:0]        rowQ;
  logic [5:0]        rowCur;
  logic [6:0]        colCur;
  logic              synced;
  logic              syncedCur;
  logic              rowVldCur;
  logic [ADDR_W-1:0] addrCur;

  logic       vld_p0, vld_p1, vld_p2, vld_p3;
  logic       blankN_p0, blankN_p1, blankN_p2, blankN_p3;
  logic       hs_p0, hs_p1, hs_p2, hs_p3;
  logic       vs_p0, vs_p1, vs_p2, vs_p3;
  logic [2:0] xLo_p0, xLo_p1, xLo_p2, xLo_p3;
  logic [3:0] line_p0, line_p1;
  logic [3:0] fg_p2, fg_p3;
  logic [3:0] bg_p2, bg_p3;
  logic       pixOn;

  // Line/row of the pixel currently presented; follows iY changes so the
  // address issued at the sample edge already reflects a new scanline.
  always_comb begin
    lineCur = lineQ;
    rowCur  = rowQ;
    if (vga.iY == 10'd0) begin
      lineCur = '0;
      rowCur  = '0;
    end else if (vga.iY != prevY) begin
      if (lineQ == LAST_LINE) begin
        lineCur = '0;
        rowCur  = (rowQ == 6'h3F) ? rowQ : rowQ + 6'd1;
      end else begin
        lineCur = lineQ + 4'd1;
      end
    end
  end

  always_comb begin
    colCur    = (vga.iX[9:3] > LAST_COL) ? LAST_COL : vga.iX[9:3];
    rowVldCur = (rowCur < ROW_LIM);
    syncedCur = synced | ((vga.iX == 10'd0) && (vga.iY == 10'd0));
    addrCur   = '0;
    if (rowVldCur)
      addrCur = ADDR_W'(rowCur) * ADDR_W'(COLS) + ADDR_W'(colCur);
  end

`ifdef CURSOR_EN
  localparam logic [3:0] CUR_LINE = 4'(CELL_H - 2);

  logic       vsPrev;
  logic [4:0] frameCnt;
  logic       curHit;
  logic       cur_p0, cur_p1, cur_p2, cur_p3;

  // Frame counter advances on each entry into vertical sync; bit 4 is the blink phase.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vsPrev   <= ~VS_ACT;
      frameCnt <= '0;
    end else begin
      vsPrev <= vga.iVGA_VS;
      if ((vga.iVGA_VS == VS_ACT) && (vsPrev != VS_ACT))
        frameCnt <= frameCnt + 5'd1;
    end
  end

  always_comb begin
    curHit = frameCnt[4] && (rowCur == {1'b0, vga.iCURSOR_ROW}) &&
             (colCur == vga.iCURSOR_COL) && (lineCur >= CUR_LINE);
  end

  always_ff @(posedge iVGA_CLK) begin
    cur_p0 <= curHit;
    cur_p1 <= cur_p0;
    cur_p2 <= cur_p1;
    cur_p3 <= cur_p2;
  end
`endif

  always_comb begin
    pixOn = vga.iFONT_DATA[~xLo_p3];
`ifdef CURSOR_EN
    if (cur_p3) pixOn = 1'b1;
`endif
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prevY          <= '0;
      lineQ          <= '0;
      rowQ           <= '0;
      synced         <= 1'b0;
      vga.oCHAR_ADDR <= '0;
      vga.oFONT_ADDR <= '0;
      vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
      blankN_p0 <= 1'b0; blankN_p1 <= 1'b0; blankN_p2 <= 1'b0; blankN_p3 <= 1'b0;
      hs_p0 <= ~HS_ACT; hs_p1 <= ~HS_ACT; hs_p2 <= ~HS_ACT; hs_p3 <= ~HS_ACT;
      vs_p0 <= ~VS_ACT; vs_p1 <= ~VS_ACT; vs_p2 <= ~VS_ACT; vs_p3 <= ~VS_ACT;
      vga.oVGA_R       <= '0;
      vga.oVGA_G       <= '0;
      vga.oVGA_B       <= '0;
      vga.oVGA_HS      <= ~HS_ACT;
      vga.oVGA_VS      <= ~VS_ACT;
      vga.oVGA_BLANK_N <= 1'b0;
    end else begin
      // E0: sample timing inputs, issue char RAM address
      prevY          <= vga.iY;
      lineQ          <= lineCur;
      rowQ           <= rowCur;
      synced         <= syncedCur;
      vga.oCHAR_ADDR <= addrCur;
      vld_p0         <= syncedCur & rowVldCur;
      blankN_p0      <= vga.iVGA_BLANK_N;
      hs_p0          <= vga.iVGA_HS;
      vs_p0          <= vga.iVGA_VS;
      // E1: char RAM read in flight
      vld_p1    <= vld_p0;
      blankN_p1 <= blankN_p0;
      hs_p1     <= hs_p0;
      vs_p1     <= vs_p0;
      // E2: char word arrives, issue font ROM address
      vga.oFONT_ADDR <= {vga.iCHAR_DATA[7:0], line_p1};
      vld_p2    <= vld_p1;
      blankN_p2 <= blankN_p1;
      hs_p2     <= hs_p1;
      vs_p2     <= vs_p1;
      // E3: font ROM read in flight
      vld_p3    <= vld_p2;
      blankN_p3 <= blankN_p2;
      hs_p3     <= hs_p2;
      vs_p3     <= vs_p2;
      // E4: font row arrives, drive DAC
      if (vld_p3 && blankN_p3)
        {vga.oVGA_R, vga.oVGA_G, vga.oVGA_B} <= pixOn ? paletteRgb(fg_p3) : paletteRgb(bg_p3);
      else
        {vga.oVGA_R, vga.oVGA_G, vga.oVGA_B} <= '0;
      vga.oVGA_HS      <= hs_p3;
      vga.oVGA_VS      <= vs_p3;
      vga.oVGA_BLANK_N <= blankN_p3;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    xLo_p0  <= vga.iX[2:0];
    line_p0 <= lineCur;
    xLo_p1  <= xLo_p0;
    line_p1 <= line_p0;
    xLo_p2  <= xLo_p1;
    fg_p2   <= vga.iCHAR_DATA[11:8];
    bg_p2   <= vga.iCHAR_DATA[15:12];
    xLo_p3  <= xLo_p2;
    fg_p3   <= fg_p2;
    bg_p3   <= bg_p2;
  end
endmodule
